// File: rtl/dev_port_fifo_pkg.sv
// Shared definitions for the device port: destination field layout and broadcast address.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dev_port_fifo_pkg;

    // The destination ID occupies the top DEST_W bits of every bus word (MSB-aligned).
    localparam int DEST_W = 8;

    // Default destination accepted by every device.
    localparam logic [DEST_W-1:0] BROADCAST_DEFAULT = 8'hFF;

    // Widest word dest_of() can handle; callers zero-extend narrower words.
    localparam int WORD_MAX = 256;

    // Extract the destination field of a word whose MSB sits at index 'msb'.
    function automatic logic [DEST_W-1:0] dest_of(input logic [WORD_MAX-1:0] word,
                                                  input logic [7:0]          msb);
        return word[msb -: DEST_W];
    endfunction

endpackage

// File: rtl/dev_port_fifo_sync_fifo_fwft.sv
// Circular-buffer FIFO with first-word-fall-through head; count/full/empty are registered.
// Latency: a word written at edge N is visible on rd_data after edge N; no bypass path.
// Backpressure: writes while full are dropped (ovf pulses) unless a read frees a slot the same cycle.
// Ports: clk/reset (sync, active-low); wr/wr_data in; rd in; rd_data/full/empty/count out; ovf = dropped write this cycle.
module sync_fifo_fwft #(
    parameter int profundidad = 8,
    parameter int BITS        = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr,
    input  logic [BITS-1:0]                  wr_data,
    input  logic                             rd,
    output logic [BITS-1:0]                  rd_data,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(profundidad+1)-1:0] count,
    output logic                             ovf
);
    localparam int AW = $clog2(profundidad);
    localparam int CW = $clog2(profundidad + 1);

    logic [BITS-1:0] mem [profundidad];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   occ;
    logic            do_rd;
    logic            do_wr;

    // A read only happens when there is something to read; a full FIFO still
    // accepts a write when the same-cycle read frees the head slot.
    assign do_rd = rd && (occ != '0);
    assign do_wr = wr && ((occ != CW'(profundidad)) || do_rd);
    assign ovf   = wr && !do_wr;

    assign rd_data = mem[rd_ptr];
    assign full    = (occ == CW'(profundidad));
    assign empty   = (occ == '0);
    assign count   = occ;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_wr && reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because profundidad is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/dev_port_fifo.sv
// Per-device bus port: TX FIFO toward the bus, address-filtered RX FIFO toward the agent, overflow counters.
// Latency: one cycle write-to-visible on both sides; heads are combinational (FWFT).
// Backpressure: none upstream; overflowing words are dropped and counted (saturating).
// Ports: clk/reset; agent wr_en/wr_data/full, rd_valid/rd_data/rd_en; bus pndng/D_pop/pop, push/D_push; tx_count, tx_ovf_cnt, rx_ovf_cnt.
module dev_port_fifo
    import dev_port_fifo_pkg::*;
#(
    parameter int          profundidad = 8,
    parameter int          BITS        = 32,
    parameter logic [7:0]  ID          = 8'd0,
    parameter logic [7:0]  broadcast   = BROADCAST_DEFAULT,
    parameter int          CNT_W       = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [BITS-1:0]                  wr_data,
    output logic                             full,
    output logic                             pndng,
    output logic [BITS-1:0]                  D_pop,
    input  logic                             pop,
    input  logic                             push,
    input  logic [BITS-1:0]                  D_push,
    output logic                             rd_valid,
    output logic [BITS-1:0]                  rd_data,
    input  logic                             rd_en,
    output logic [$clog2(profundidad+1)-1:0] tx_count,
    output logic [CNT_W-1:0]                 tx_ovf_cnt,
    output logic [CNT_W-1:0]                 rx_ovf_cnt
);
    localparam int CW = $clog2(profundidad + 1);

    logic          tx_empty;
    logic          tx_ovf;
    logic          rx_full;
    logic          rx_empty;
    logic [CW-1:0] rx_count;
    logic          rx_ovf;
    logic [7:0]    rx_dest;
    logic          rx_accept;
    logic          rx_unused;

    sync_fifo_fwft #(.profundidad(profundidad), .BITS(BITS)) u_tx (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr_en),
        .wr_data (wr_data),
        .rd      (pop),
        .rd_data (D_pop),
        .full    (full),
        .empty   (tx_empty),
        .count   (tx_count),
        .ovf     (tx_ovf)
    );

    // Only words addressed to this device or to broadcast enter the RX FIFO;
    // everything else is discarded without touching the overflow counter.
    assign rx_dest   = dest_of(WORD_MAX'(D_push), 8'(BITS - 1));
    assign rx_accept = push && ((rx_dest == ID) || (rx_dest == broadcast));

    sync_fifo_fwft #(.profundidad(profundidad), .BITS(BITS)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .wr      (rx_accept),
        .wr_data (D_push),
        .rd      (rd_en),
        .rd_data (rd_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count),
        .ovf     (rx_ovf)
    );

    // RX occupancy/full are not exported; fold them into one sink.
    assign rx_unused = ^{rx_full, rx_count};

    assign pndng    = !tx_empty;
    assign rd_valid = !rx_empty;

    // Overflow counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_ovf_cnt <= '0;
            rx_ovf_cnt <= '0;
        end else begin
            if (tx_ovf && (tx_ovf_cnt != '1)) begin
                tx_ovf_cnt <= tx_ovf_cnt + 1'b1;
            end
            if (rx_ovf && (rx_ovf_cnt != '1)) begin
                rx_ovf_cnt <= rx_ovf_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dev_port_fifo.sv
// Directed bench for dev_port_fifo with a queue scoreboard for both FIFOs.
// Latency: inputs driven on the falling edge, outputs sampled before the next rising edge.
// Backpressure: n/a.
module tb_dev_port_fifo;
    import dev_port_fifo_pkg::*;

    localparam int         DEPTH = 8;
    localparam logic [7:0] MY_ID = 8'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        full;
    logic        pndng;
    logic [31:0] D_pop;
    logic        pop;
    logic        push;
    logic [31:0] D_push;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_en;
    logic [3:0]  tx_count;
    logic [15:0] tx_ovf_cnt;
    logic [15:0] rx_ovf_cnt;

    dev_port_fifo #(.profundidad(DEPTH), .BITS(32), .ID(MY_ID), .broadcast(8'hFF), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .pndng      (pndng),
        .D_pop      (D_pop),
        .pop        (pop),
        .push       (push),
        .D_push     (D_push),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_en      (rd_en),
        .tx_count   (tx_count),
        .tx_ovf_cnt (tx_ovf_cnt),
        .rx_ovf_cnt (rx_ovf_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard state
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic [15:0] exp_tx_ovf;
    logic [15:0] exp_rx_ovf;
    logic [31:0] last_tx;
    logic [31:0] last_rx;
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, check heads being consumed, update the model,
    // then advance to the next falling edge and return inputs to idle.
    task automatic step(input logic w, input logic [31:0] wd, input logic p,
                        input logic ps, input logic [31:0] pd, input logic r,
                        input logic rs_n);
        int   sz;
        logic popped;
        logic [7:0] d;
        wr_en = w; wr_data = wd; pop = p; push = ps; D_push = pd; rd_en = r; reset = rs_n;
        #1;
        if (!rs_n) begin
            tx_q.delete();
            rx_q.delete();
            exp_tx_ovf = '0;
            exp_rx_ovf = '0;
        end else begin
            sz     = tx_q.size();
            popped = p && (sz > 0);
            if (popped) begin
                check("d_pop", {32'd0, D_pop}, {32'd0, tx_q[0]});
                last_tx = tx_q.pop_front();
            end
            if (w) begin
                if (sz < DEPTH || popped) tx_q.push_back(wd);
                else if (exp_tx_ovf != 16'hFFFF) exp_tx_ovf++;
            end
            sz     = rx_q.size();
            popped = r && (sz > 0);
            if (popped) begin
                check("rd_data", {32'd0, rd_data}, {32'd0, rx_q[0]});
                last_rx = rx_q.pop_front();
            end
            d = dest_of(WORD_MAX'(pd), 8'd31);
            if (ps && (d == MY_ID || d == BROADCAST_DEFAULT)) begin
                if (sz < DEPTH || popped) rx_q.push_back(pd);
                else if (exp_rx_ovf != 16'hFFFF) exp_rx_ovf++;
            end
        end
        @(negedge clk);
        wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0; reset = 1'b1;
    endtask

    task automatic status(input string tag);
        check({tag, ".pndng"},    {63'd0, pndng},      {63'd0, tx_q.size() != 0});
        check({tag, ".full"},     {63'd0, full},       {63'd0, tx_q.size() == DEPTH});
        check({tag, ".tx_count"}, {60'd0, tx_count},   64'(tx_q.size()));
        check({tag, ".rd_valid"}, {63'd0, rd_valid},   {63'd0, rx_q.size() != 0});
        check({tag, ".tx_ovf"},   {48'd0, tx_ovf_cnt}, {48'd0, exp_tx_ovf});
        check({tag, ".rx_ovf"},   {48'd0, rx_ovf_cnt}, {48'd0, exp_rx_ovf});
    endtask

    task automatic tx_wr(input logic [31:0] v, input logic p);
        step(1'b1, v, p, 1'b0, 32'd0, 1'b0, 1'b1);
    endtask
    task automatic tx_pop();
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    endtask
    task automatic rx_push(input logic [31:0] v);
        step(1'b0, 32'd0, 1'b0, 1'b1, v, 1'b0, 1'b1);
    endtask
    task automatic rx_read();
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_data = '0; pop = 1'b0;
        push = 1'b0; D_push = '0; rd_en = 1'b0;
        exp_tx_ovf = '0; exp_rx_ovf = '0; last_tx = '0; last_rx = '0;
        @(negedge clk);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

        // Reset values
        check("rst.pndng",    {63'd0, pndng},      64'd0);
        check("rst.full",     {63'd0, full},       64'd0);
        check("rst.rd_valid", {63'd0, rd_valid},   64'd0);
        check("rst.tx_count", {60'd0, tx_count},   64'd0);
        check("rst.tx_ovf",   {48'd0, tx_ovf_cnt}, 64'd0);
        check("rst.rx_ovf",   {48'd0, rx_ovf_cnt}, 64'd0);

        // Three back-to-back TX writes; pndng visible right after the first edge
        tx_wr(32'h0200_0001, 1'b0);
        check("t1.pndng_first", {63'd0, pndng}, 64'd1);
        tx_wr(32'h0200_0002, 1'b0);
        tx_wr(32'h0200_0003, 1'b0);
        check("t1.count3", {60'd0, tx_count}, 64'd3);
        status("t1");
        for (int i = 0; i < 3; i++) tx_pop();
        check("t1.last", {32'd0, last_tx}, 64'h0200_0003);
        status("t1.drained");

        // Fill to full, then one overflowing write
        for (int i = 0; i < DEPTH; i++) tx_wr(32'h0200_0010 + 32'(i), 1'b0);
        check("t2.full", {63'd0, full}, 64'd1);
        tx_wr(32'h0200_00EE, 1'b0);
        check("t2.ovf", {48'd0, tx_ovf_cnt}, 64'd1);
        status("t2.full");
        for (int i = 0; i < DEPTH; i++) tx_pop();
        check("t2.last", {32'd0, last_tx}, 64'h0200_0017);
        status("t2.drained");

        // Simultaneous write and pop while full
        for (int i = 0; i < DEPTH; i++) tx_wr(32'h0200_0100 + 32'(i), 1'b0);
        tx_wr(32'h0200_0BEE, 1'b1);
        check("t3.popped_head", {32'd0, last_tx}, 64'h0200_0100);
        check("t3.count8",      {60'd0, tx_count}, 64'd8);
        check("t3.ovf_same",    {48'd0, tx_ovf_cnt}, 64'd1);
        status("t3");
        for (int i = 0; i < DEPTH; i++) tx_pop();
        check("t3.last", {32'd0, last_tx}, 64'h0200_0BEE);

        // RX address filter
        rx_push(32'h02AA_AAAA);
        check("t4.rd_valid", {63'd0, rd_valid}, 64'd1);
        rx_push(32'hFF55_5555);
        rx_push(32'h0312_3456);
        status("t4");
        rx_read();
        check("t4.first",  {32'd0, last_rx}, 64'h02AA_AAAA);
        rx_read();
        check("t4.second", {32'd0, last_rx}, 64'hFF55_5555);
        check("t4.empty",  {63'd0, rd_valid}, 64'd0);
        check("t4.no_ovf", {48'd0, rx_ovf_cnt}, 64'd0);

        // RX overflow, then reset mid-stream
        for (int i = 0; i < DEPTH + 1; i++)
            rx_push((i % 2 == 0) ? (32'h0200_0000 + 32'(i)) : (32'hFF00_0000 + 32'(i)));
        check("t5.rx_ovf", {48'd0, rx_ovf_cnt}, 64'd1);
        tx_wr(32'h0200_0055, 1'b0);
        tx_wr(32'h0200_0066, 1'b0);
        tx_wr(32'h0200_0077, 1'b0);
        tx_wr(32'h0200_0088, 1'b0);
        status("t5.pre");
        step(1'b1, 32'h0200_0099, 1'b1, 1'b1, 32'h0200_0099, 1'b1, 1'b0);
        check("t5.pndng",    {63'd0, pndng},      64'd0);
        check("t5.rd_valid", {63'd0, rd_valid},   64'd0);
        check("t5.tx_count", {60'd0, tx_count},   64'd0);
        check("t5.rx_ovf0",  {48'd0, rx_ovf_cnt}, 64'd0);
        status("t5.post");

        // Pop / read on empty FIFOs: ignored
        tx_pop();
        rx_read();
        status("t6.empty_ops");
        check("t6.count", {60'd0, tx_count}, 64'd0);
        // Write and pop together while empty: write succeeds, pop ignored
        tx_wr(32'h02C0_FFEE, 1'b1);
        check("t6.wr_pop_empty", {60'd0, tx_count}, 64'd1);
        status("t6.wp");
        tx_pop();
        check("t6.last", {32'd0, last_tx}, 64'h02C0_FFEE);
        status("t6.end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dev_port_fifo.md
# dev_port_fifo

Per-device port that sits between one device agent and the bus generator/arbiter; one instance per device. TX side buffers words written by the agent and presents them to the bus as `pndng`/`D_pop`/`pop`. RX side accepts words the bus delivers on `push`/`D_push`, keeps only those addressed to this device or to broadcast, and buffers them for the agent. Overflow events are counted on both sides for the checker.

## Interface
- `profundidad`, 8: depth of each FIFO in words; power of two, ≥ 2.
- `BITS`, 32: word width; bits `[BITS-1:BITS-8]` are the destination ID, the remainder is payload.
- `ID`, 0: this device's 8-bit address.
- `broadcast`, 8'hFF: destination ID accepted by every device.
- `CNT_W`, 16: width of the overflow counters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk`.
- `wr_en` in 1: agent writes `wr_data` into the TX FIFO.
- `wr_data` in BITS: agent TX word.
- `full` out 1: TX FIFO holds `profundidad` words.
- `pndng` out 1: TX FIFO non-empty.
- `D_pop` out BITS: TX head word (first-word-fall-through).
- `pop` in 1: bus consumes the TX head.
- `push` in 1: bus delivers `D_push`.
- `D_push` in BITS: word from the bus.
- `rd_valid` out 1: RX FIFO non-empty.
- `rd_data` out BITS: RX head word (FWFT).
- `rd_en` in 1: agent consumes the RX head.
- `tx_count` out $clog2(profundidad+1): TX occupancy.
- `tx_ovf_cnt` out CNT_W: writes dropped because TX was full.
- `rx_ovf_cnt` out CNT_W: addressed words dropped because RX was full.

## Operation
- Both FIFOs: circular buffer, read/write pointers wrap modulo `profundidad`, separate occupancy counter of width $clog2(profundidad+1).
- TX write: `wr_en` with TX not full stores `wr_data` at the write pointer.
- TX write when full and `pop`=0: word is dropped and `tx_ovf_cnt` increments.
- TX write when full and `pop`=1 in the same cycle: both operations succeed and occupancy stays at `profundidad`.
- TX `pop` when empty: ignored. No counter changes and no pointer movement.
- TX `wr_en` and `pop` both asserted while empty: the write succeeds and the pop is ignored. There is no bypass path.
- RX accept: `push`=1 and `D_push[BITS-1:BITS-8]` equals `ID` or `broadcast`. Words with any other destination are silently discarded.
- RX accept when RX is full and `rd_en`=0: word is dropped and `rx_ovf_cnt` increments.
- RX accept when RX is full and `rd_en`=1: both operations succeed.
- RX `rd_en` when empty: ignored.
- Overflow counters saturate at 2^CNT_W−1 and never wrap.
- Stored words are unmodified, including the destination field.

## Timing
- All state is updated on the rising edge of `clk`.
- `full`, `pndng`, `rd_valid` and `tx_count` are decoded from registered occupancy, so they change the cycle after the causing edge.
- `D_pop` and `rd_data` are combinational reads of the head entry, valid whenever `pndng`/`rd_valid` is 1. When the FIFO is empty their value is don't-care.
- Write-to-visible latency is one cycle: a word written at edge N raises `pndng` (or `rd_valid`) after edge N and is poppable at edge N+1.
- The bus samples `D_pop` on the same edge on which it asserts `pop`.
- Reset (`reset`=0 at an edge) has priority over all inputs in that cycle. It clears pointers, occupancies and counters, which flushes both FIFOs mid-operation.
- Output values after reset: `full`=0, `pndng`=0, `rd_valid`=0, `tx_count`=0, `tx_ovf_cnt`=0, `rx_ovf_cnt`=0.
- Memory array contents are not reset.

## Structure
- Shared package holds:
  - the destination-field slice constant (8 bits, MSB-aligned);
  - the default `broadcast` value;
  - the function `dest_of(word)`.
  The testbench agent and checker import the same package.
- One sub-module, `sync_fifo_fwft`, parameterised by `profundidad` and `BITS`. It exposes wr/rd/full/empty/count and a one-cycle `ovf` pulse, and is instantiated twice (TX and RX).
- Address filtering and the saturating counters live in the top level.

## Test plan
- Reset, then write 3 TX words 0x02000001..03 back-to-back. Required: `pndng` rises after the first edge, `tx_count`=3, and three pops return the words in order.
- Fill TX with 8 words, then write a 9th with `pop`=0. Required: `full`=1, `tx_ovf_cnt`=1, and all 8 original words drain intact.
- With TX full, assert `wr_en` and `pop` together. Required: `tx_count` stays 8, the old head leaves, and the new word becomes the last popped.
- With `ID`=2, bus pushes 0x02AAAAAA, 0xFF555555 and 0x03123456. Required: RX holds exactly the first two, in order, and `rx_ovf_cnt`=0.
- Push 9 addressed words into RX with no reads. Required: `rx_ovf_cnt`=1; then assert `reset`=0 for one cycle mid-stream. Required: all occupancies and counters are 0, and `pndng`=`rd_valid`=0 on the next cycle.
- Pop on empty TX and `rd_en` on empty RX. Required: no state change and counters unchanged.
